// File: rtl/conv_out_seq_ctrl.sv
// Output sequencer for the 1-D convolution engine: strided x/f address generation,
// PIPE_LAT-aligned accumulator control and AXI-stream valid. Optional m_last_y via CONV_OUT_LAST_EN.
module conv_out_seq_ctrl #(
   parameter int X_MEM_SIZE       = 8,
   parameter int F_MEM_SIZE       = 4,
   parameter int STRIDE           = 1,
   parameter int PIPE_LAT         = 2,
   parameter int X_MEM_ADDR_WIDTH = $clog2(X_MEM_SIZE),
   parameter int F_MEM_ADDR_WIDTH = $clog2(F_MEM_SIZE)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        conv_start,
   input  logic                        conv_abort,
   input  logic                        m_ready_y,
   output logic [X_MEM_ADDR_WIDTH-1:0] xmem_addr,
   output logic [F_MEM_ADDR_WIDTH-1:0] fmem_addr,
   output logic                        mem_rd_en,
   output logic                        en_accum,
   output logic                        accum_first,
   output logic                        m_valid_y,
   output logic                        conv_busy,
`ifdef CONV_OUT_LAST_EN
   output logic                        conv_done,
   output logic                        m_last_y
`else
   output logic                        conv_done
`endif
);

   localparam int N_OUT  = (X_MEM_SIZE - F_MEM_SIZE) / STRIDE + 1;
   localparam int TAP_W  = (F_MEM_SIZE > 1) ? $clog2(F_MEM_SIZE) : 1;
   localparam int OUT_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int BASE_W = (X_MEM_SIZE > 1) ? $clog2(X_MEM_SIZE) : 1;
   localparam int DRN_W  = $clog2(PIPE_LAT + 1);

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, HOLD, DONE} state_t;

   state_t              state;
   logic [BASE_W-1:0]   base;
   logic [TAP_W-1:0]    tap;
   logic [OUT_W-1:0]    out_cnt;
   logic [DRN_W-1:0]    drain_cnt;
   logic                rd_first;
   logic [PIPE_LAT-1:0] tag_v;
   logic [PIPE_LAT-1:0] tag_f;

   logic last_tap;
   logic last_out;
   logic drain_end;

   assign last_tap  = (tap == TAP_W'(F_MEM_SIZE - 1));
   assign last_out  = (out_cnt == OUT_W'(N_OUT - 1));
   assign drain_end = (drain_cnt == DRN_W'(PIPE_LAT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         base      <= '0;
         tap       <= '0;
         out_cnt   <= '0;
         drain_cnt <= '0;
         rd_first  <= 1'b0;
         xmem_addr <= '0;
         fmem_addr <= '0;
         mem_rd_en <= 1'b0;
         m_valid_y <= 1'b0;
         conv_busy <= 1'b0;
         conv_done <= 1'b0;
      end else if (conv_abort) begin
         state     <= IDLE;
         base      <= '0;
         tap       <= '0;
         out_cnt   <= '0;
         drain_cnt <= '0;
         rd_first  <= 1'b0;
         xmem_addr <= '0;
         fmem_addr <= '0;
         mem_rd_en <= 1'b0;
         m_valid_y <= 1'b0;
         conv_busy <= 1'b0;
         conv_done <= 1'b0;
      end else begin
         conv_done <= 1'b0;
         case (state)
            IDLE: begin
               base    <= '0;
               tap     <= '0;
               out_cnt <= '0;
               if (conv_start) begin
                  state     <= FETCH;
                  conv_busy <= 1'b1;
                  mem_rd_en <= 1'b1;
                  rd_first  <= 1'b1;
                  xmem_addr <= '0;
                  fmem_addr <= '0;
               end
            end
            FETCH: begin
               rd_first <= 1'b0;
               if (last_tap) begin
                  state     <= DRAIN;
                  mem_rd_en <= 1'b0;
                  drain_cnt <= '0;
               end else begin
                  tap       <= tap + 1'b1;
                  xmem_addr <= X_MEM_ADDR_WIDTH'(base + tap + 1'b1);
                  fmem_addr <= F_MEM_ADDR_WIDTH'(tap + 1'b1);
               end
            end
            DRAIN: begin
               // the last tag leaves the pipe on this edge, so the accumulator is final right after it
               if (drain_end) begin
                  state     <= HOLD;
                  m_valid_y <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (m_ready_y) begin
                  m_valid_y <= 1'b0;
                  if (last_out) begin
                     state     <= DONE;
                     conv_done <= 1'b1;
                  end else begin
                     state     <= FETCH;
                     out_cnt   <= out_cnt + 1'b1;
                     base      <= BASE_W'(base + STRIDE);
                     tap       <= '0;
                     mem_rd_en <= 1'b1;
                     rd_first  <= 1'b1;
                     xmem_addr <= X_MEM_ADDR_WIDTH'(base + STRIDE);
                     fmem_addr <= '0;
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               conv_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // tag enters one edge after the read strobe so its exit lines up with the product
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_v <= '0;
         tag_f <= '0;
      end else if (conv_abort) begin
         tag_v <= '0;
         tag_f <= '0;
      end else begin
         tag_v <= PIPE_LAT'({tag_v, mem_rd_en});
         tag_f <= PIPE_LAT'({tag_f, rd_first});
      end
   end

   assign en_accum    = tag_v[PIPE_LAT-1];
   assign accum_first = tag_v[PIPE_LAT-1] & tag_f[PIPE_LAT-1];

`ifdef CONV_OUT_LAST_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_last_y <= 1'b0;
      end else if (conv_abort) begin
         m_last_y <= 1'b0;
      end else if (state == DRAIN && drain_end) begin
         m_last_y <= last_out;
      end else if (state == HOLD && m_ready_y) begin
         m_last_y <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_conv_out_seq_ctrl.sv
// Self-checking bench for conv_out_seq_ctrl: three parameter sets, randomized ready/start/abort,
// checked cycle by cycle against a window timeline derived from the convolution rules.
module tb_conv_out_seq_ctrl;

   logic clk = 1'b0;
   logic reset;
   logic start [3];
   logic abort [3];
   logic ready [3];

   logic [2:0] x0;
   logic [1:0] f0;
   logic [3:0] x1;
   logic [1:0] f1;
   logic [1:0] x2;
   logic [0:0] f2;
   logic rd_o [3], ea_o [3], af_o [3], mv_o [3], bsy_o [3], dn_o [3];
   logic [31:0] xa [3], fa [3], rd [3], ea [3], af [3], mv [3], bsy [3], dn [3];
`ifdef CONV_OUT_LAST_EN
   logic lst_o [3];
   logic [31:0] lst [3];
`endif

   int n_vec = 0;
   int n_err = 0;
   int cur = 0;

   always #5 clk = ~clk;

   conv_out_seq_ctrl #(.X_MEM_SIZE(8), .F_MEM_SIZE(4), .STRIDE(1), .PIPE_LAT(2)) u_dut0 (
      .clk(clk), .reset(reset), .conv_start(start[0]), .conv_abort(abort[0]), .m_ready_y(ready[0]),
      .xmem_addr(x0), .fmem_addr(f0), .mem_rd_en(rd_o[0]), .en_accum(ea_o[0]),
      .accum_first(af_o[0]), .m_valid_y(mv_o[0]), .conv_busy(bsy_o[0]),
`ifdef CONV_OUT_LAST_EN
      .m_last_y(lst_o[0]),
`endif
      .conv_done(dn_o[0]));

   conv_out_seq_ctrl #(.X_MEM_SIZE(9), .F_MEM_SIZE(3), .STRIDE(2), .PIPE_LAT(2)) u_dut1 (
      .clk(clk), .reset(reset), .conv_start(start[1]), .conv_abort(abort[1]), .m_ready_y(ready[1]),
      .xmem_addr(x1), .fmem_addr(f1), .mem_rd_en(rd_o[1]), .en_accum(ea_o[1]),
      .accum_first(af_o[1]), .m_valid_y(mv_o[1]), .conv_busy(bsy_o[1]),
`ifdef CONV_OUT_LAST_EN
      .m_last_y(lst_o[1]),
`endif
      .conv_done(dn_o[1]));

   conv_out_seq_ctrl #(.X_MEM_SIZE(4), .F_MEM_SIZE(1), .STRIDE(1), .PIPE_LAT(1),
                       .F_MEM_ADDR_WIDTH(1)) u_dut2 (
      .clk(clk), .reset(reset), .conv_start(start[2]), .conv_abort(abort[2]), .m_ready_y(ready[2]),
      .xmem_addr(x2), .fmem_addr(f2), .mem_rd_en(rd_o[2]), .en_accum(ea_o[2]),
      .accum_first(af_o[2]), .m_valid_y(mv_o[2]), .conv_busy(bsy_o[2]),
`ifdef CONV_OUT_LAST_EN
      .m_last_y(lst_o[2]),
`endif
      .conv_done(dn_o[2]));

   always_comb begin
      xa[0] = 32'(x0);
      xa[1] = 32'(x1);
      xa[2] = 32'(x2);
      fa[0] = 32'(f0);
      fa[1] = 32'(f1);
      fa[2] = 32'(f2);
      for (int k = 0; k < 3; k++) begin
         rd[k]  = 32'(rd_o[k]);
         ea[k]  = 32'(ea_o[k]);
         af[k]  = 32'(af_o[k]);
         mv[k]  = 32'(mv_o[k]);
         bsy[k] = 32'(bsy_o[k]);
         dn[k]  = 32'(dn_o[k]);
`ifdef CONV_OUT_LAST_EN
         lst[k] = 32'(lst_o[k]);
`endif
      end
   end

   function automatic int p_x(input int i);
      return (i == 0) ? 8 : (i == 1) ? 9 : 4;
   endfunction
   function automatic int p_f(input int i);
      return (i == 0) ? 4 : (i == 1) ? 3 : 1;
   endfunction
   function automatic int p_s(input int i);
      return (i == 1) ? 2 : 1;
   endfunction
   function automatic int p_l(input int i);
      return (i == 2) ? 1 : 2;
   endfunction
   function automatic int n_out(input int i);
      return (p_x(i) - p_f(i)) / p_s(i) + 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s (dut %0d, t=%0t): got %0d expected %0d", tag, cur, $time, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic rdy, input logic ab, input logic keep);
      start[i] = keep ? 1'b1 : 1'($urandom_range(0, 1));
      ready[i] = rdy;
      abort[i] = ab;
   endtask

   task automatic idle_checks(input int i);
      check("idle rd_en", rd[i], 0);
      check("idle m_valid", mv[i], 0);
      check("idle en_accum", ea[i], 0);
      check("idle accum_first", af[i], 0);
      check("idle busy", bsy[i], 0);
      check("idle done", dn[i], 0);
`ifdef CONV_OUT_LAST_EN
      check("idle last", lst[i], 0);
`endif
   endtask

   task automatic zero_checks(input int i);
      idle_checks(i);
      check("zero xaddr", xa[i], 0);
      check("zero faddr", fa[i], 0);
   endtask

   task automatic abort_tail(input int i);
      abort[i] = 1'b0;
      start[i] = 1'b0;
      idle_checks(i);
      step();
      idle_checks(i);
   endtask

   // One convolution on dut i. Cycle c of a window counts from the edge that entered FETCH.
   // ab_w/ab_c: abort in window ab_w at in-window cycle ab_c (0 = HOLD handshake cycle).
   task automatic run_conv(input int i, input int hold_max, input int bp_w,
                           input int ab_w, input int ab_c, input logic keep);
      int f, l, s, n, h, t;
      f = p_f(i);
      l = p_l(i);
      s = p_s(i);
      n = n_out(i);
      cur = i;
      start[i] = 1'b1;
      abort[i] = 1'b0;
      ready[i] = 1'($urandom_range(0, 1));
      step();
      for (int w = 0; w < n; w++) begin
         for (int c = 1; c <= f + l; c++) begin
            t = c - l - 1;
            check("rd_en", rd[i], (c <= f) ? 1 : 0);
            if (c <= f) begin
               check("xaddr", xa[i], w * s + c - 1);
               check("faddr", fa[i], c - 1);
            end
            check("en_accum", ea[i], (t >= 0 && t < f) ? 1 : 0);
            check("accum_first", af[i], (t == 0) ? 1 : 0);
            check("m_valid", mv[i], 0);
            check("busy", bsy[i], 1);
            check("done", dn[i], 0);
            if (w == ab_w && c == ab_c) begin
               drive(i, 1'($urandom_range(0, 1)), 1'b1, keep);
               step();
               abort_tail(i);
               return;
            end
            drive(i, 1'($urandom_range(0, 1)), 1'b0, keep);
            step();
         end
         h = (w == bp_w) ? 10 : $urandom_range(0, hold_max);
         for (int j = 0; j <= h; j++) begin
            check("hold m_valid", mv[i], 1);
            check("hold rd_en", rd[i], 0);
            check("hold en_accum", ea[i], 0);
            check("hold busy", bsy[i], 1);
            check("hold done", dn[i], 0);
`ifdef CONV_OUT_LAST_EN
            check("hold last", lst[i], (w == n - 1) ? 1 : 0);
`endif
            if (w == ab_w && ab_c == 0 && j == h) begin
               drive(i, 1'b1, 1'b1, keep);
               step();
               abort_tail(i);
               return;
            end
            drive(i, (j == h), 1'b0, keep);
            step();
         end
      end
      check("done pulse", dn[i], 1);
      check("done m_valid", mv[i], 0);
      check("done rd_en", rd[i], 0);
      check("done busy", bsy[i], 1);
      drive(i, 1'($urandom_range(0, 1)), 1'b0, keep);
      step();
      check("post done", dn[i], 0);
      check("post busy", bsy[i], 0);
      check("post m_valid", mv[i], 0);
      check("post rd_en", rd[i], 0);
      if (!keep) start[i] = 1'b0;
   endtask

   task automatic async_reset_test();
      cur = 0;
      start[0] = 1'b1;
      step();
      start[0] = 1'b0;
      check("pre-reset rd_en", rd[0], 1);
      step();
      check("pre-reset xaddr", xa[0], 1);
      #3 reset = 1'b1;
      #1;
      zero_checks(0);
      #2 reset = 1'b0;
      step();
      idle_checks(0);
   endtask

   initial begin
      int ab_w, ab_c;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         start[k] = 1'b0;
         abort[k] = 1'b0;
         ready[k] = 1'b0;
      end
      #12;
      for (int k = 0; k < 3; k++) begin
         cur = k;
         zero_checks(k);
      end
      @(negedge clk);
      reset = 1'b0;
      step();

      run_conv(0, 0, -1, -1, -1, 1'b0);
      run_conv(0, 0, 1, -1, -1, 1'b0);
      run_conv(0, 2, -1, 2, 0, 1'b0);
      run_conv(0, 2, -1, -1, -1, 1'b0);
      async_reset_test();
      run_conv(0, 1, -1, -1, -1, 1'b0);
      run_conv(0, 1, -1, -1, -1, 1'b1);
      run_conv(0, 1, -1, -1, -1, 1'b1);
      start[0] = 1'b0;
      step();
      idle_checks(0);

      for (int i = 0; i < 3; i++) begin
         run_conv(i, 0, -1, -1, -1, 1'b0);
         for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 2) == 0) begin
               ab_w = $urandom_range(0, n_out(i) - 1);
               ab_c = $urandom_range(0, p_f(i) + p_l(i));
            end else begin
               ab_w = -1;
               ab_c = -1;
            end
            run_conv(i, 3, -1, ab_w, ab_c, 1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
